// File: rtl/register_bank_pkg.sv
// Shared widths and dump FSM state encoding for the DLX general-purpose register file.
package register_bank_pkg;

  localparam int DEF_NB_DATA = 32;
  localparam int DEF_NB_REG  = 5;
  localparam int DEF_N_REGS  = 32;

  typedef enum logic [1:0] {
    DUMP_IDLE = 2'd0,
    DUMP_SEND = 2'd1,
    DUMP_DONE = 2'd2
  } dump_state_e;

endpackage

// File: rtl/register_bank_dump.sv
// Register dump sequencer: walks every register index and presents one beat per
// index on a valid/ready port, loading each beat from a bypassed read port in the top.
module register_bank_dump
  import register_bank_pkg::*;
#(
  parameter int NB_DATA = DEF_NB_DATA,
  parameter int NB_REG  = DEF_NB_REG,
  parameter int N_REGS  = DEF_N_REGS
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               ready_i,
  input  logic [NB_DATA-1:0] rd_data_i,
  output logic [NB_REG-1:0]  rd_addr_o,
  output logic               valid_o,
  output logic [NB_REG-1:0]  addr_o,
  output logic [NB_DATA-1:0] data_o,
  output dump_state_e        state_o
);

  localparam logic [NB_REG-1:0] LAST_IDX = NB_REG'(N_REGS - 1);

  dump_state_e        state_q, state_d;
  logic [NB_REG-1:0]  index_q, index_d;
  logic [NB_DATA-1:0] data_q, data_d;

  // Handshake: a beat transfers on a rising edge where valid_o and ready_i are both
  // high; while valid_o is high and ready_i is low, addr_o/data_o hold unchanged.
  // rd_addr_o names the register whose bypassed value is loaded at the next edge.
  always_comb begin
    rd_addr_o = '0;
    if (state_q == DUMP_SEND) rd_addr_o = index_q + NB_REG'(1);
  end

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    data_d  = data_q;
    case (state_q)
      DUMP_IDLE: begin
        if (start_i) begin
          state_d = DUMP_SEND;
          index_d = '0;
          data_d  = rd_data_i;
        end
      end
      DUMP_SEND: begin
        if (ready_i) begin
          if (index_q == LAST_IDX) begin
            state_d = DUMP_DONE;
          end else begin
            index_d = index_q + NB_REG'(1);
            data_d  = rd_data_i;
          end
        end
      end
      DUMP_DONE: state_d = DUMP_IDLE;
      default:   state_d = DUMP_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= DUMP_IDLE;
      index_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = (state_q == DUMP_SEND);
  assign addr_o  = (state_q == DUMP_SEND) ? index_q : '0;
  assign data_o  = (state_q == DUMP_SEND) ? data_q : '0;
  assign state_o = state_q;

endmodule

// File: rtl/register_bank.sv
// DLX general-purpose register file: WB-stage write port, two ID read ports with
// same-cycle write bypass, and a streamed dump port for the debug unit.
module register_bank
  import register_bank_pkg::*;
#(
  parameter int NB_DATA = DEF_NB_DATA,
  parameter int NB_REG  = DEF_NB_REG,
  parameter int N_REGS  = DEF_N_REGS
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_WB_reg_write,
  input  logic [NB_REG-1:0]  i_WB_selected_reg,
  input  logic [NB_DATA-1:0] i_WB_selected_data,
  input  logic [NB_REG-1:0]  i_ID_rs_addr,
  input  logic [NB_REG-1:0]  i_ID_rt_addr,
  output logic [NB_DATA-1:0] o_ID_rs_data,
  output logic [NB_DATA-1:0] o_ID_rt_data,
  input  logic               i_dump_start,
  input  logic               i_dump_ready,
  output logic               o_dump_valid,
  output logic [NB_REG-1:0]  o_dump_addr,
  output logic [NB_DATA-1:0] o_dump_data,
  output logic               o_dump_busy,
  output logic               o_dump_done
);

  logic [NB_DATA-1:0] regs_q [N_REGS];
  logic [NB_REG-1:0]  dump_rd_addr;
  logic [NB_DATA-1:0] dump_rd_data;
  dump_state_e        dump_state;

  // r0 is hardwired to zero, and a write in flight is forwarded to readers of the
  // same register so the ID stage never sees the stale value.
  function automatic logic [NB_DATA-1:0] read_reg(input logic [NB_REG-1:0] addr);
    if (addr == '0)
      read_reg = '0;
    else if (i_WB_reg_write && (addr == i_WB_selected_reg))
      read_reg = i_WB_selected_data;
    else
      read_reg = regs_q[addr];
  endfunction

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < N_REGS; i++) regs_q[i] <= '0;
    end else if (i_WB_reg_write && (i_WB_selected_reg != '0)) begin
      regs_q[i_WB_selected_reg] <= i_WB_selected_data;
    end
  end

  always_comb begin
    o_ID_rs_data = read_reg(i_ID_rs_addr);
    o_ID_rt_data = read_reg(i_ID_rt_addr);
    dump_rd_data = read_reg(dump_rd_addr);
  end

  register_bank_dump #(
    .NB_DATA(NB_DATA),
    .NB_REG (NB_REG),
    .N_REGS (N_REGS)
  ) u_dump (
    .clk_i    (i_clock),
    .rst_i    (i_reset),
    .start_i  (i_dump_start),
    .ready_i  (i_dump_ready),
    .rd_data_i(dump_rd_data),
    .rd_addr_o(dump_rd_addr),
    .valid_o  (o_dump_valid),
    .addr_o   (o_dump_addr),
    .data_o   (o_dump_data),
    .state_o  (dump_state)
  );

  assign o_dump_busy = (dump_state != DUMP_IDLE);
  assign o_dump_done = (dump_state == DUMP_DONE);

endmodule

// File: tb/tb_register_bank.sv
// Directed self-checking bench for register_bank: reset, r0, bypass, full dump,
// stalled dump with late writes, ignored restart, and reset in the middle of a dump.
module tb_register_bank;

  localparam int NB_DATA = 32;
  localparam int NB_REG  = 5;
  localparam int N_REGS  = 32;

  logic               i_clock;
  logic               i_reset;
  logic               i_WB_reg_write;
  logic [NB_REG-1:0]  i_WB_selected_reg;
  logic [NB_DATA-1:0] i_WB_selected_data;
  logic [NB_REG-1:0]  i_ID_rs_addr;
  logic [NB_REG-1:0]  i_ID_rt_addr;
  logic [NB_DATA-1:0] o_ID_rs_data;
  logic [NB_DATA-1:0] o_ID_rt_data;
  logic               i_dump_start;
  logic               i_dump_ready;
  logic               o_dump_valid;
  logic [NB_REG-1:0]  o_dump_addr;
  logic [NB_DATA-1:0] o_dump_data;
  logic               o_dump_busy;
  logic               o_dump_done;

  logic [NB_DATA-1:0] model [N_REGS];
  int vec_cnt = 0;
  int err_cnt = 0;

  register_bank #(
    .NB_DATA(NB_DATA),
    .NB_REG (NB_REG),
    .N_REGS (N_REGS)
  ) dut (
    .i_clock           (i_clock),
    .i_reset           (i_reset),
    .i_WB_reg_write    (i_WB_reg_write),
    .i_WB_selected_reg (i_WB_selected_reg),
    .i_WB_selected_data(i_WB_selected_data),
    .i_ID_rs_addr      (i_ID_rs_addr),
    .i_ID_rt_addr      (i_ID_rt_addr),
    .o_ID_rs_data      (o_ID_rs_data),
    .o_ID_rt_data      (o_ID_rt_data),
    .i_dump_start      (i_dump_start),
    .i_dump_ready      (i_dump_ready),
    .o_dump_valid      (o_dump_valid),
    .o_dump_addr       (o_dump_addr),
    .o_dump_data       (o_dump_data),
    .o_dump_busy       (o_dump_busy),
    .o_dump_done       (o_dump_done)
  );

  // clock / reset
  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic do_write(input logic [NB_REG-1:0] a, input logic [NB_DATA-1:0] d);
    i_WB_reg_write     = 1'b1;
    i_WB_selected_reg  = a;
    i_WB_selected_data = d;
    tick();
    i_WB_reg_write = 1'b0;
    if (a != '0) model[a] = d;
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    i_WB_reg_write = 1'b0; i_WB_selected_reg = '0; i_WB_selected_data = '0;
    i_ID_rs_addr = 5'd0; i_ID_rt_addr = 5'd31;
    i_dump_start = 1'b0; i_dump_ready = 1'b0;
    for (int i = 0; i < N_REGS; i++) model[i] = '0;
    tick(); tick();
    vec_cnt++;
    if ({o_dump_valid, o_dump_busy, o_dump_done} !== 3'b000) begin
      err_cnt++;
      $display("FAIL reset_flags: got valid/busy/done=%b%b%b exp 000", o_dump_valid, o_dump_busy, o_dump_done);
    end
    vec_cnt++;
    if (o_dump_addr !== 5'd0 || o_dump_data !== 32'h0) begin
      err_cnt++;
      $display("FAIL reset_dump_port: got addr=%0d data=%h exp 0/0", o_dump_addr, o_dump_data);
    end
    i_reset = 1'b0;
    tick();
    vec_cnt++;
    if (o_ID_rs_data !== 32'h0 || o_ID_rt_data !== 32'h0) begin
      err_cnt++;
      $display("FAIL reset_read: got rs=%h rt=%h exp 0/0", o_ID_rs_data, o_ID_rt_data);
    end
  endtask

  task automatic test_r0();
    i_ID_rs_addr = 5'd0;
    i_WB_reg_write = 1'b1; i_WB_selected_reg = 5'd0; i_WB_selected_data = 32'hDEAD;
    #1;
    vec_cnt++;
    if (o_ID_rs_data !== 32'h0) begin
      err_cnt++;
      $display("FAIL r0_no_bypass: got %h exp 00000000", o_ID_rs_data);
    end
    tick();
    i_WB_reg_write = 1'b0;
    #1;
    vec_cnt++;
    if (o_ID_rs_data !== 32'h0) begin
      err_cnt++;
      $display("FAIL r0_write_dropped: got %h exp 00000000", o_ID_rs_data);
    end
  endtask

  task automatic test_bypass();
    i_ID_rs_addr = 5'd5; i_ID_rt_addr = 5'd6;
    i_WB_reg_write = 1'b1; i_WB_selected_reg = 5'd5; i_WB_selected_data = 32'h0000_00AA;
    #1;
    vec_cnt++;
    if (o_ID_rs_data !== 32'h0000_00AA) begin
      err_cnt++;
      $display("FAIL bypass_rs: got %h exp 000000aa", o_ID_rs_data);
    end
    vec_cnt++;
    if (o_ID_rt_data !== 32'h0) begin
      err_cnt++;
      $display("FAIL bypass_rt_other: got %h exp 00000000", o_ID_rt_data);
    end
    tick();
    i_WB_reg_write = 1'b0;
    model[5] = 32'h0000_00AA;
    #1;
    vec_cnt++;
    if (o_ID_rs_data !== 32'h0000_00AA) begin
      err_cnt++;
      $display("FAIL stored_rs: got %h exp 000000aa", o_ID_rs_data);
    end
    i_WB_reg_write = 1'b1; i_WB_selected_reg = 5'd6; i_WB_selected_data = 32'h1234_5678;
    #1;
    vec_cnt++;
    if (o_ID_rt_data !== 32'h1234_5678) begin
      err_cnt++;
      $display("FAIL bypass_rt: got %h exp 12345678", o_ID_rt_data);
    end
    tick();
    i_WB_reg_write = 1'b0;
    model[6] = 32'h1234_5678;
    #1;
    vec_cnt++;
    if (o_ID_rt_data !== 32'h1234_5678 || o_ID_rs_data !== 32'h0000_00AA) begin
      err_cnt++;
      $display("FAIL stored_rs_rt: got rs=%h rt=%h exp 000000aa/12345678", o_ID_rs_data, o_ID_rt_data);
    end
  endtask

  task automatic test_dump_full();
    do_write(5'd7, 32'h11);
    do_write(5'd9, 32'h22);
    i_dump_ready = 1'b1;
    i_dump_start = 1'b1;
    tick();
    i_dump_start = 1'b0;
    for (int b = 0; b < N_REGS; b++) begin
      vec_cnt++;
      if (o_dump_valid !== 1'b1 || o_dump_addr !== 5'(b) || o_dump_data !== model[b]) begin
        err_cnt++;
        $display("FAIL full_beat%0d: got v=%b addr=%0d data=%h exp v=1 addr=%0d data=%h",
                 b, o_dump_valid, o_dump_addr, o_dump_data, b, model[b]);
      end
      if (b == 7 || b == 9) begin
        vec_cnt++;
        if (o_dump_data !== ((b == 7) ? 32'h11 : 32'h22)) begin
          err_cnt++;
          $display("FAIL full_written_beat%0d: got %h exp %h", b, o_dump_data, (b == 7) ? 32'h11 : 32'h22);
        end
      end
      tick();
    end
    vec_cnt++;
    if (o_dump_done !== 1'b1 || o_dump_valid !== 1'b0 || o_dump_busy !== 1'b1) begin
      err_cnt++;
      $display("FAIL full_done: got done=%b valid=%b busy=%b exp 1/0/1", o_dump_done, o_dump_valid, o_dump_busy);
    end
    tick();
    vec_cnt++;
    if (o_dump_done !== 1'b0 || o_dump_busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL full_idle: got done=%b busy=%b exp 0/0", o_dump_done, o_dump_busy);
    end
  endtask

  task automatic test_stall_and_restart();
    logic [NB_DATA-1:0] exp_d;
    logic [NB_DATA-1:0] nxt;
    int b, stall, guard;
    i_dump_ready = 1'b1;
    i_dump_start = 1'b1;
    tick();
    i_dump_start = 1'b0;
    b = 0; stall = 0; guard = 0; exp_d = 32'h0; nxt = 32'h0;
    while (b < N_REGS && guard < 200) begin
      guard++;
      vec_cnt++;
      if (o_dump_valid !== 1'b1 || o_dump_addr !== 5'(b) || o_dump_data !== exp_d) begin
        err_cnt++;
        $display("FAIL stall_beat%0d: got v=%b addr=%0d data=%h exp v=1 addr=%0d data=%h",
                 b, o_dump_valid, o_dump_addr, o_dump_data, b, exp_d);
      end
      if (b == 3) begin
        vec_cnt++;
        if (o_dump_data !== 32'h0) begin
          err_cnt++;
          $display("FAIL stall_hold_old: got %h exp 00000000", o_dump_data);
        end
      end
      if (b == 10) begin
        vec_cnt++;
        if (o_dump_data !== 32'h44) begin
          err_cnt++;
          $display("FAIL late_write_beat10: got %h exp 00000044", o_dump_data);
        end
      end
      i_dump_ready = 1'b1;
      i_WB_reg_write = 1'b0;
      if (b == 3 && stall < 5) begin
        i_dump_ready = 1'b0;
        if (stall == 0) begin
          i_WB_reg_write = 1'b1; i_WB_selected_reg = 5'd3; i_WB_selected_data = 32'h33;
        end
        stall++;
      end
      if (b == 6) i_dump_start = 1'b1;
      if (b == 9) begin
        i_WB_reg_write = 1'b1; i_WB_selected_reg = 5'd10; i_WB_selected_data = 32'h44;
      end
      if (i_WB_reg_write) model[i_WB_selected_reg] = i_WB_selected_data;
      if (b < N_REGS - 1) nxt = model[b + 1];
      tick();
      i_WB_reg_write = 1'b0;
      i_dump_start = 1'b0;
      if (i_dump_ready) begin
        b++;
        exp_d = nxt;
      end
    end
    if (guard >= 200) begin
      vec_cnt++;
      err_cnt++;
      $display("FAIL stall_timeout: got beat %0d exp %0d", b, N_REGS);
    end
    vec_cnt++;
    if (o_dump_done !== 1'b1) begin
      err_cnt++;
      $display("FAIL stall_done: got %b exp 1", o_dump_done);
    end
    tick();
    vec_cnt++;
    if (o_dump_busy !== 1'b0 || o_dump_done !== 1'b0) begin
      err_cnt++;
      $display("FAIL stall_idle: got busy=%b done=%b exp 0/0", o_dump_busy, o_dump_done);
    end
    i_ID_rs_addr = 5'd3; i_ID_rt_addr = 5'd10;
    #1;
    vec_cnt++;
    if (o_ID_rs_data !== 32'h33 || o_ID_rt_data !== 32'h44) begin
      err_cnt++;
      $display("FAIL stall_writes_stored: got r3=%h r10=%h exp 00000033/00000044", o_ID_rs_data, o_ID_rt_data);
    end
  endtask

  task automatic test_reset_mid_dump();
    i_dump_ready = 1'b1;
    i_dump_start = 1'b1;
    tick();
    i_dump_start = 1'b0;
    repeat (12) tick();
    vec_cnt++;
    if (o_dump_addr !== 5'd12 || o_dump_valid !== 1'b1) begin
      err_cnt++;
      $display("FAIL mid_index12: got addr=%0d valid=%b exp 12/1", o_dump_addr, o_dump_valid);
    end
    #2;
    i_reset = 1'b1;
    #1;
    vec_cnt++;
    if ({o_dump_valid, o_dump_busy, o_dump_done} !== 3'b000) begin
      err_cnt++;
      $display("FAIL mid_reset_flags: got valid/busy/done=%b%b%b exp 000", o_dump_valid, o_dump_busy, o_dump_done);
    end
    for (int i = 0; i < N_REGS; i++) model[i] = '0;
    i_ID_rs_addr = 5'd7; i_ID_rt_addr = 5'd10;
    #1;
    vec_cnt++;
    if (o_ID_rs_data !== 32'h0 || o_ID_rt_data !== 32'h0) begin
      err_cnt++;
      $display("FAIL mid_reset_regs: got r7=%h r10=%h exp 0/0", o_ID_rs_data, o_ID_rt_data);
    end
    #2;
    i_reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      vec_cnt++;
      if (o_dump_done !== 1'b0 || o_dump_busy !== 1'b0) begin
        err_cnt++;
        $display("FAIL mid_no_done_c%0d: got done=%b busy=%b exp 0/0", c, o_dump_done, o_dump_busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_r0();
    test_bypass();
    test_dump_full();
    test_stall_and_restart();
    test_reset_mid_dump();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/register_bank.md
# register_bank

General-purpose register file of the MIPS-DLX pipeline: the consumer end of the write-back interface. It accepts the write produced by the WB stage (write enable, destination register, selected data) and serves the two ID-stage source operands with same-cycle write bypass. It also streams its full contents to the debug unit over a valid/ready port for post-run register dumps.

## Interface

- NB_DATA, 32, register and data width
- NB_REG, 5, register address width
- N_REGS, 32, number of registers (must equal 2**NB_REG)

- i_clock  in  1  system clock, all state on rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_WB_reg_write  in  1  write enable from WB stage
- i_WB_selected_reg  in  NB_REG  destination register from WB stage
- i_WB_selected_data  in  NB_DATA  write data from WB stage
- i_ID_rs_addr  in  NB_REG  source register A address
- i_ID_rt_addr  in  NB_REG  source register B address
- o_ID_rs_data  out  NB_DATA  source A data (combinational)
- o_ID_rt_data  out  NB_DATA  source B data (combinational)
- i_dump_start  in  1  request full register dump
- i_dump_ready  in  1  debug unit accepts current beat
- o_dump_valid  out  1  beat present on dump port
- o_dump_addr  out  NB_REG  register index of current beat
- o_dump_data  out  NB_DATA  register value of current beat
- o_dump_busy  out  1  dump in progress (state != IDLE)
- o_dump_done  out  1  one-cycle pulse after final beat

## Operation

- Write: on rising edge, if i_WB_reg_write and i_WB_selected_reg != 0, reg[i_WB_selected_reg] <= i_WB_selected_data. Writes to r0 discarded; r0 always reads 0.
- Read (per port): addr == 0 -> 0; else i_WB_reg_write and addr == i_WB_selected_reg -> i_WB_selected_data (bypass); else stored value.
- Dump FSM states: IDLE, SEND, DONE.
  - IDLE: i_dump_start -> SEND, index <= 0, o_dump_data <= bypassed value of reg[0] (always 0).
  - SEND: o_dump_valid = 1, o_dump_addr = index. Transfer when valid and ready: if index == N_REGS-1 -> DONE, else index <= index+1 and o_dump_data <= bypassed value of reg[index+1] at that edge.
  - DONE: o_dump_done = 1 for exactly one cycle, then IDLE.
- o_dump_addr/o_dump_data held stable while valid and not ready; later writes to a pending register are captured only when that beat is loaded.
- i_dump_start ignored outside IDLE. Writes and ID reads operate normally during a dump.

## Timing

- Reset (asynchronous): all registers 0, state IDLE, index 0; o_dump_valid, o_dump_busy, o_dump_done, o_dump_addr, o_dump_data all 0. ID read outputs follow the read rule (0 unless bypassing).
- Reset mid-dump: immediate return to IDLE, valid drops without completing the beat, no done pulse.
- Read latency: 0 cycles (combinational); write visible in stored array after the edge, via bypass in the same cycle.
- Dump: start sampled at edge k -> valid from after edge k; with ready held high, beats on edges k+1..k+32, done high during cycle after edge k+32, IDLE after edge k+33.
- Ready low stalls indefinitely with no data loss; index never wraps past N_REGS-1.

## Structure

- Shared package (register_bank_pkg): NB_DATA, NB_REG, N_REGS defaults and dump state enum (IDLE, SEND, DONE).
- One sub-module: register_bank_dump (FSM, index counter, beat data register); storage array and read/bypass muxes stay in the top.

## Test plan

- Reset then read rs=0, rt=31 -> both 0; write r0=0xDEAD -> r0 still reads 0.
- Write r5=0x000000AA with rs_addr=5 in same cycle -> o_ID_rs_data=0xAA combinationally; next cycle without write still 0xAA.
- Write r7=0x11 and r9=0x22, start dump, ready high -> 32 consecutive beats, beat 7=0x11, beat 9=0x22, done pulse one cycle after beat 31, busy low after.
- Start dump, ready low 5 cycles at index 3 while writing r3=0x33 -> beat 3 data unchanged (old value); write r10=0x44 before beat 10 loads -> beat 10 = 0x44.
- Assert i_dump_start while busy -> ignored, sequence unaffected; assert i_reset at index 12 -> valid, busy low immediately, all registers read 0, no done pulse.
